axi_slave: RTL
==============

AXI_SLAVE -- requirements
Module: axi_slave

Interface
REQ-001 SHALL have parameter AXI_ADDRW, default 32, address width.
REQ-002 SHALL have parameter AXI_DATAW, default 32, data width; AXI_DATAW_BYTE = AXI_DATAW/8.
REQ-003 SHALL have parameter ADDR_MAX, default 32'h0000_FFFF, highest decoded byte address.
REQ-004 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports araddr in AXI_ADDRW, arprot in 3 (ignored), arvalid in 1, arready out 1.
REQ-007 SHALL have ports rdata out AXI_DATAW, rresp out 2, rvalid out 1, rready in 1.
REQ-008 SHALL have ports awaddr in AXI_ADDRW, awprot in 3 (ignored), awvalid in 1, awready out 1.
REQ-009 SHALL have ports wdata in AXI_DATAW, wstrb in AXI_DATAW_BYTE, wvalid in 1, wready out 1.
REQ-010 SHALL have ports bresp out 2, bvalid out 1, bready in 1.
REQ-011 SHALL have local-side ports: mem_addr out AXI_ADDRW, mem_wdata out AXI_DATAW, mem_wstrb out AXI_DATAW_BYTE, mem_re out 1, mem_we out 1, mem_rdata in AXI_DATAW, mem_ready in 1.

Function
REQ-012 SHALL implement an AXI4-Lite responder: one outstanding transaction, states IDLE, RD_MEM, RD_RESP, WR_MEM, WR_RESP.
REQ-013 SHALL accept AW and W independently in IDLE; awready = IDLE & !aw_held, wready = IDLE & !w_held; handshake latches addr / data+strb and sets the held flag.
REQ-014 SHALL assert arready = IDLE & !aw_held & !w_held & !(awvalid & prio_wr); prio_wr resets to 1 and toggles after every completed response, so neither direction starves.
REQ-015 SHALL, on AR handshake, latch araddr and enter RD_MEM if araddr <= ADDR_MAX, else RD_RESP with rresp=2'b10 (SLVERR), rdata=0.
REQ-016 SHALL, in RD_MEM, drive mem_re=1 and mem_addr=latched araddr until the cycle mem_ready=1, capture mem_rdata that cycle, set rresp=2'b00, and enter RD_RESP.
REQ-017 SHALL, in RD_RESP, hold rvalid=1 with stable rdata/rresp until rready=1, then return to IDLE on the next edge.
REQ-018 SHALL, when both aw_held and w_held are set, leave IDLE: in-range address with wstrb!=0 -> WR_MEM; in-range with wstrb==0 -> WR_RESP OKAY, no local access; out-of-range -> WR_RESP SLVERR, no local access.
REQ-019 SHALL, in WR_MEM, drive mem_we=1, mem_addr, mem_wdata, mem_wstrb from latched values until mem_ready=1, then enter WR_RESP with bresp=2'b00.
REQ-020 SHALL, in WR_RESP, hold bvalid=1 until bready=1, then clear both held flags and return to IDLE.
REQ-021 SHALL never assert mem_re and mem_we in the same cycle, nor arready while any write half is held.
REQ-022 SHALL have latency: AR handshake edge N -> mem_re in cycle N+1; mem_ready in cycle N+1 -> rvalid in cycle N+2. Same timing for writes, counted from the later of the AW/W handshakes.
REQ-023 SHALL accept AW and W in the same cycle, and in either order across cycles.
REQ-024 SHALL keep valid outputs asserted regardless of ready: a response never drops before its handshake.
REQ-025 SHALL ignore any address above ADDR_MAX, including the wrap case addr = all-ones, which gets SLVERR.

Reset
REQ-026 SHALL, on rst=1 at a clock edge, force state IDLE, aw_held=w_held=0, prio_wr=1, rvalid=bvalid=mem_re=mem_we=0, rdata=0, rresp=bresp=2'b00.
REQ-027 SHALL abandon any in-flight transaction when reset is asserted mid-operation, with no response issued.
REQ-028 SHALL drive arready=awready=wready=0 while rst=1.

Verification
REQ-029 SHALL verify single read: araddr=0x10, mem_rdata=0xDEADBEEF, mem_ready=1 -> rvalid two cycles after the AR handshake, rdata=0xDEADBEEF, rresp=00.
REQ-030 SHALL verify write with W three cycles before AW: addr=0x20, wdata=0x12345678, wstrb=4'b0011 -> one mem_we pulse carrying those values, then bvalid with bresp=00.
REQ-031 SHALL verify out-of-range accesses: read of 0x0001_0000 -> rresp=10, rdata=0, mem_re never asserted; write to 0xFFFF_FFFC -> bresp=10, mem_we never asserted.
REQ-032 SHALL verify backpressure: mem_ready low for 5 cycles and rready low for 4 cycles -> mem_re held 6 cycles, rvalid held with rdata stable until the handshake.
REQ-033 SHALL verify arbitration: arvalid and awvalid+wvalid asserted together continuously -> the write is served first after reset, and grants then alternate read/write.
REQ-034 SHALL verify reset in WR_MEM: rst pulsed while mem_we=1 -> next cycle mem_we=0, bvalid=0, awready=wready=1.

Source files
------------

// File: rtl/axi_if.sv
// axi_if: AXI4-Lite bus bundle with master and slave views
interface axi_if #(
  parameter int AXI_ADDRW = 32,
  parameter int AXI_DATAW = 32
);
  localparam int AXI_DATAW_BYTE = AXI_DATAW / 8;
  logic [AXI_ADDRW-1:0]      araddr;
  logic [2:0]                arprot;
  logic                      arvalid;
  logic                      arready;
  logic [AXI_DATAW-1:0]      rdata;
  logic [1:0]                rresp;
  logic                      rvalid;
  logic                      rready;
  logic [AXI_ADDRW-1:0]      awaddr;
  logic [2:0]                awprot;
  logic                      awvalid;
  logic                      awready;
  logic [AXI_DATAW-1:0]      wdata;
  logic [AXI_DATAW_BYTE-1:0] wstrb;
  logic                      wvalid;
  logic                      wready;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;
  modport master (
    output araddr, arprot, arvalid, rready, awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
  modport slave (
    input  araddr, arprot, arvalid, rready, awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_slave.sv
// axi_slave: AXI4-Lite responder serving one transaction at a time over a local memory port
module axi_slave #(
  parameter int AXI_ADDRW = 32,
  parameter int AXI_DATAW = 32,
  parameter logic [AXI_ADDRW-1:0] ADDR_MAX = 'h0000_FFFF,
  localparam int AXI_DATAW_BYTE = AXI_DATAW / 8
) (
  input  logic                      clk,
  input  logic                      rst,
  axi_if.slave                      s,
  output logic [AXI_ADDRW-1:0]      mem_addr,
  output logic [AXI_DATAW-1:0]      mem_wdata,
  output logic [AXI_DATAW_BYTE-1:0] mem_wstrb,
  output logic                      mem_re,
  output logic                      mem_we,
  input  logic [AXI_DATAW-1:0]      mem_rdata,
  input  logic                      mem_ready
);
  typedef enum logic [2:0] {IDLE, RD_MEM, RD_RESP, WR_MEM, WR_RESP} state_e;
  state_e                    state_q, state_d;
  logic                      aw_held_q, aw_held_d, w_held_q, w_held_d, prio_wr_q, prio_wr_d;
  logic [AXI_ADDRW-1:0]      araddr_q, araddr_d, awaddr_q, awaddr_d;
  logic [AXI_DATAW-1:0]      wdata_q, wdata_d, rdata_q, rdata_d;
  logic [AXI_DATAW_BYTE-1:0] wstrb_q, wstrb_d;
  logic [1:0]                rresp_q, rresp_d, bresp_q, bresp_d;
  logic                      ar_rdy, aw_rdy, w_rdy;
  logic                      ar_hs, aw_hs, w_hs, r_hs, b_hs, wr_go, ar_ok, aw_ok, rd_done;
  logic                      unused;
  assign unused = ^{s.arprot, s.awprot};
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      prio_wr_q <= 1'b1;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
      bresp_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      prio_wr_q <= prio_wr_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      bresp_q   <= bresp_d;
    end
  end
  always_ff @(posedge clk) begin
    araddr_q <= araddr_d;
    awaddr_q <= awaddr_d;
    wdata_q  <= wdata_d;
    wstrb_q  <= wstrb_d;
  end
  always_comb begin
    ar_rdy    = !rst && state_q == IDLE && !aw_held_q && !w_held_q && !(s.awvalid && prio_wr_q);
    aw_rdy    = !rst && state_q == IDLE && !aw_held_q;
    w_rdy     = !rst && state_q == IDLE && !w_held_q;
    s.arready = ar_rdy;
    s.awready = aw_rdy;
    s.wready  = w_rdy;
    s.rvalid  = state_q == RD_RESP;
    s.rdata   = rdata_q;
    s.rresp   = rresp_q;
    s.bvalid  = state_q == WR_RESP;
    s.bresp   = bresp_q;
    mem_re    = state_q == RD_MEM;
    mem_we    = state_q == WR_MEM;
    mem_addr  = state_q == RD_MEM ? araddr_q : awaddr_q;
    mem_wdata = wdata_q;
    mem_wstrb = wstrb_q;
  end
  always_comb begin
    ar_hs     = s.arvalid && ar_rdy;
    aw_hs     = s.awvalid && aw_rdy;
    w_hs      = s.wvalid && w_rdy;
    r_hs      = state_q == RD_RESP && s.rready;
    b_hs      = state_q == WR_RESP && s.bready;
    rd_done   = state_q == RD_MEM && mem_ready;
    aw_held_d = b_hs ? 1'b0 : aw_held_q || aw_hs;
    w_held_d  = b_hs ? 1'b0 : w_held_q || w_hs;
    prio_wr_d = prio_wr_q ^ (r_hs || b_hs);
    araddr_d  = ar_hs ? s.araddr : araddr_q;
    awaddr_d  = aw_hs ? s.awaddr : awaddr_q;
    wdata_d   = w_hs ? s.wdata : wdata_q;
    wstrb_d   = w_hs ? s.wstrb : wstrb_q;
    ar_ok     = s.araddr <= ADDR_MAX;
    aw_ok     = awaddr_d <= ADDR_MAX;
    wr_go     = state_q == IDLE && !ar_hs && aw_held_d && w_held_d;
    rdata_d   = ar_hs ? '0 : rd_done ? mem_rdata : rdata_q;
    rresp_d   = ar_hs ? (ar_ok ? 2'b00 : 2'b10) : rd_done ? 2'b00 : rresp_q;
    bresp_d   = wr_go ? (aw_ok ? 2'b00 : 2'b10) : bresp_q;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = ar_hs ? (ar_ok ? RD_MEM : RD_RESP) :
                         wr_go ? (aw_ok && wstrb_d != '0 ? WR_MEM : WR_RESP) : IDLE;
      RD_MEM:  state_d = mem_ready ? RD_RESP : RD_MEM;
      RD_RESP: state_d = s.rready ? IDLE : RD_RESP;
      WR_MEM:  state_d = mem_ready ? WR_RESP : WR_MEM;
      WR_RESP: state_d = s.bready ? IDLE : WR_RESP;
      default: state_d = IDLE;
    endcase
  end
endmodule
